// File: rtl/div_pkg.sv
// Shared divider types: FSM state encoding and default operand width.
// Imported by seq_divider.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    FIN
  } state_t;

endpackage

// File: rtl/addsub_n.sv
// N-bit adder/subtractor: sum = a + b (sub=0) or a - b (sub=1).
// Ports: a, b operands; sub select; sum result; cout carry (1 = no borrow).
module addsub_n #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] b_x;

  assign b_x = b ^ {N{sub}};
  assign {cout, sum} = a + b_x + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, signed/unsigned, one quotient bit per cycle.
// Ports: clk, rst_n (sync, active-low), start/signed_op/dividend/divisor in;
// quotient/remainder/busy/done/dbz/ovf registered out.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] r_w;
  logic [WIDTH-1:0] b_w;
  logic             neg_q;
  logic             neg_r;
  logic             dbz_w;
  logic             ovf_w;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic             unused_msb;

  assign a_neg = signed_op & dividend[WIDTH-1];
  assign b_neg = signed_op & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  // Partial remainder stays below the divisor, so WIDTH bits hold it;
  // the shifted value needs one extra bit before the compare.
  assign r_sh = {r_w, q_w[WIDTH-1]};

  addsub_n #(
    .N(WIDTH + 1)
  ) u_sub (
    .a   (r_sh),
    .b   ({1'b0, b_w}),
    .sub (1'b1),
    .sum (diff),
    .cout(ge)
  );

  // Result after a successful subtract is < divisor: MSB always zero.
  assign unused_msb = diff[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      q_w       <= '0;
      r_w       <= '0;
      b_w       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dbz_w     <= 1'b0;
      ovf_w     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              q_w   <= '1;
              r_w   <= dividend;
              dbz_w <= 1'b1;
              ovf_w <= 1'b0;
              state <= FIN;
            end else begin
              q_w   <= a_mag;
              b_w   <= b_mag;
              r_w   <= '0;
              cnt   <= '0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              dbz_w <= 1'b0;
              ovf_w <= signed_op &&
                       dividend == MIN &&
                       divisor == '1;
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          q_w <= {q_w[WIDTH-2:0], ge};
          r_w <= ge ? diff[WIDTH-1:0]
                    : r_sh[WIDTH-1:0];
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          // MIN/-1: |MIN| negated wraps back to MIN.
          if (neg_q) q_w <= -q_w;
          if (neg_r) r_w <= -r_w;
          busy  <= 1'b0;
          state <= FIN;
        end
        FIN: begin
          quotient  <= q_w;
          remainder <= r_w;
          dbz       <= dbz_w;
          ovf       <= ovf_w;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
